// File: rtl/seq_shift_add_multiplier.sv
// Sequential signed shift-add multiplier, steps_per_cycle bits per clock.
// Optional MULT_SAT_EN adds a saturated fixed-point result and overflow flag.
module seq_shift_add_multiplier #(
  parameter int bits            = 16,
  parameter int steps_per_cycle = 1,
  parameter int frac_bits       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [bits-1:0]   a,
  input  logic [bits-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*bits-1:0] product
`ifdef MULT_SAT_EN
  ,
  output logic [bits-1:0]   sat_result,
  output logic              overflow
`endif
);

  localparam int N  = bits / steps_per_cycle;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [bits-1:0] mcand;
  logic [2*bits:0] p;
  logic [2*bits:0] p_next;
  logic            accept;
  logic            last_cyc;

  assign in_ready = (state == IDLE) ||
                    ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign last_cyc = (cnt == CW'(N - 1));

  // The step on a's sign bit subtracts, giving an exact signed product.
  always_comb begin
    logic [bits:0] hi;
    logic [bits:0] bx;
    p_next = p;
    bx     = {mcand[bits-1], mcand};
    hi     = '0;
    for (int k = 0; k < steps_per_cycle; k++) begin
      hi = p_next[2*bits:bits];
      if (p_next[0]) begin
        if ((int'(cnt) * steps_per_cycle + k) == bits - 1)
          hi = hi - bx;
        else
          hi = hi + bx;
      end
      p_next = {hi[bits], hi, p_next[bits-1:1]};
    end
  end

`ifdef MULT_SAT_EN
  logic signed [2*bits-1:0] s_shift;
  logic        [bits-1:0]   sat_next;
  logic                     ovf_next;
  logic signed [2*bits-1:0] s_max;
  logic signed [2*bits-1:0] s_min;

  assign s_max = {{(bits+1){1'b0}}, {(bits-1){1'b1}}};
  assign s_min = {{(bits+1){1'b1}}, {(bits-1){1'b0}}};

  always_comb begin
    s_shift  = $signed(p_next[2*bits-1:0]) >>> frac_bits;
    sat_next = s_shift[bits-1:0];
    ovf_next = 1'b0;
    if (s_shift > s_max) begin
      sat_next = {1'b0, {(bits-1){1'b1}}};
      ovf_next = 1'b1;
    end else if (s_shift < s_min) begin
      sat_next = {1'b1, {(bits-1){1'b0}}};
      ovf_next = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      mcand      <= '0;
      p          <= '0;
      out_valid  <= 1'b0;
      product    <= '0;
`ifdef MULT_SAT_EN
      sat_result <= '0;
      overflow   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            mcand <= b;
            p     <= {{(bits+1){1'b0}}, a};
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          p   <= p_next;
          cnt <= cnt + 1'b1;
          if (last_cyc) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            product    <= p_next[2*bits-1:0];
`ifdef MULT_SAT_EN
            sat_result <= sat_next;
            overflow   <= ovf_next;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (accept) begin
              mcand <= b;
              p     <= {{(bits+1){1'b0}}, a};
              cnt   <= '0;
              state <= RUN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
